dsp_in_pipe: RTL

Parametrised successor to the DSP slice dual-register input stage, used for the A, B and D operand paths.
- Selects a direct or cascade operand, either statically or per cycle.
- Passes it through 0-4 register stages, each with its own clock enable.
- Drives three outputs: the X-mux operand, a multiplier operand tapped from any selectable stage, and a cascade output tapped at a parametrised depth.
- Carries a valid bit alongside the data so downstream control can track bubbles created by enables and clears.

---
 rtl/dsp_in_pipe.sv | 100 ++++++++++
 1 files changed

// File: rtl/dsp_in_pipe.sv
// Operand input stage for the A/B/D paths: direct or cascade select, up to four
// independently enabled register stages, and X / multiplier / cascade taps with valid tracking.
module dsp_in_pipe #(
    parameter int    WIDTH     = 18,
    parameter int    DEPTH     = 2,
    parameter int    CASCDEPTH = 2,
    parameter string INPUT_SEL = "DIRECT"
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic             SRST,
    input  logic [3:0]       CE,
    input  logic             IN_SEL,
    input  logic [WIDTH-1:0] DIN,
    input  logic [WIDTH-1:0] CIN,
    input  logic             VIN,
    input  logic [2:0]       TAPSEL,
    output logic [WIDTH-1:0] XOUT,
    output logic [WIDTH-1:0] MULT_OUT,
    output logic [WIDTH-1:0] COUT,
    output logic             VOUT,
    output logic             VMULT
);

    if (WIDTH < 1 || WIDTH > 48 || DEPTH < 0 || DEPTH > 4 ||
        CASCDEPTH < 0 || CASCDEPTH > DEPTH) begin : g_param_err
        $error("dsp_in_pipe: illegal parameters WIDTH=%0d DEPTH=%0d CASCDEPTH=%0d",
               WIDTH, DEPTH, CASCDEPTH);
    end

    // Unrecognised INPUT_SEL strings fall back to the direct operand.
    localparam bit SEL_DYN = (INPUT_SEL == "DYNAMIC");
    localparam bit SEL_CAS = (INPUT_SEL == "CASCADE");

    logic [WIDTH-1:0] s0;
    logic             v0;
    logic [WIDTH-1:0] sq    [1:4];
    logic             sv    [1:4];
    logic [WIDTH-1:0] tap_d [0:4];
    logic             tap_v [0:4];
    logic [2:0]       tap_idx;

    assign s0 = SEL_DYN ? (IN_SEL ? CIN : DIN) : (SEL_CAS ? CIN : DIN);
    assign v0 = VIN;

    // Stages above DEPTH never leave reset and are trimmed as constants.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            for (int k = 1; k <= 4; k++) begin
                sq[k] <= '0;
                sv[k] <= 1'b0;
            end
        end else begin
            if (DEPTH >= 1) begin
                if (SRST) begin
                    sq[1] <= '0;
                    sv[1] <= 1'b0;
                end else if (CE[0]) begin
                    sq[1] <= s0;
                    sv[1] <= v0;
                end
            end
            for (int k = 2; k <= 4; k++) begin
                if (k <= DEPTH) begin
                    if (SRST) begin
                        sq[k] <= '0;
                        sv[k] <= 1'b0;
                    end else if (CE[k-1]) begin
                        sq[k] <= sq[k-1];
                        sv[k] <= sv[k-1];
                    end
                end
            end
        end
    end

    // Tap views 0..4; indices beyond DEPTH alias the last real stage, which gives tap saturation.
    for (genvar k = 0; k <= 4; k++) begin : g_tap
        localparam int K = (k < DEPTH) ? k : DEPTH;
        if (K == 0) begin : g_comb
            assign tap_d[k] = s0;
            assign tap_v[k] = v0;
        end else begin : g_reg
            assign tap_d[k] = sq[K];
            assign tap_v[k] = sv[K];
        end
    end

    assign tap_idx  = (TAPSEL > 3'd4) ? 3'd4 : TAPSEL;
    assign XOUT     = tap_d[4];
    assign VOUT     = tap_v[4];
    assign MULT_OUT = tap_d[tap_idx];
    assign VMULT    = tap_v[tap_idx];
    assign COUT     = tap_d[CASCDEPTH];

    // Inputs and top stages that some parameterisations leave unread.
    logic unused_ok;
    assign unused_ok = ^{clk, RSTn, SRST, CE, IN_SEL, CIN, sq[4], sv[4]};

endmodule
